basilisk_writeback: RTL and testbench

Merges the two floating-point result streams of the basilisk FPU, the multiplier result stream and the adder result stream, into a single register-file writeback stream. It sits directly downstream of the multiply pipeline (`mult_result_command`) and the add pipeline, arbitrating fairly between them. It also accumulates sticky IEEE exception flags (fflags) for the CSR unit.

---
 rtl/basilisk_pkg.sv | 36 +++
 rtl/std_stream_intf.sv | 12 +
 rtl/basilisk_rr_arbiter2.sv | 37 +++
 rtl/basilisk_writeback.sv | 108 ++++++++++
 tb/tb_basilisk_writeback.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/basilisk_pkg.sv
// basilisk FPU shared types: result/writeback payloads and fflags bit indices.
// Used by the mult/add pipelines and the writeback merge stage.
package basilisk;

    localparam int unsigned FLAGS_W  = 5;
    localparam int unsigned FFLAG_NV = 4;
    localparam int unsigned FFLAG_DZ = 3;
    localparam int unsigned FFLAG_OF = 2;
    localparam int unsigned FFLAG_UF = 1;
    localparam int unsigned FFLAG_NX = 0;

    typedef struct packed {
        logic [4:0]         dest_reg_addr;
        logic [31:0]        result;
        logic [FLAGS_W-1:0] flags;
    } basilisk_result_t;

    typedef struct packed {
        logic [4:0]         dest_reg_addr;
        logic [31:0]        result;
        logic [FLAGS_W-1:0] flags;
    } basilisk_writeback_t;

    localparam int unsigned RESULT_W = $bits(basilisk_result_t);

    function automatic basilisk_writeback_t to_writeback(
        input basilisk_result_t r
    );
        basilisk_writeback_t w;
        w.dest_reg_addr = r.dest_reg_addr;
        w.result        = r.result;
        w.flags         = r.flags;
        return w;
    endfunction

endpackage

// File: rtl/std_stream_intf.sv
// Generic valid/ready stream carrying a W-bit payload.
// Modports: in (consumer side), out (producer side).
interface std_stream_intf #(
    parameter int unsigned W = 1
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport in  (input valid, input data, output ready);
    modport out (output valid, output data, input ready);
endinterface

// File: rtl/basilisk_rr_arbiter2.sv
// Two-input round-robin arbiter with its last_grant register.
// Ports: req[1:0] (0=add, 1=mult), accept (granted transfer), grant[1:0].
module basilisk_rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    // 1 = mult was granted last; reset to 1 so add wins first contention
    logic last_q;
    logic last_d;

    always_comb begin
        grant = req;
        if (&req) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (accept && |grant) begin
            last_d = grant[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/basilisk_writeback.sv
// Merges mult and add result streams into one writeback stream (round-robin)
// and accumulates sticky fflags {NV,DZ,OF,UF,NX}; output reg or pass-through.
module basilisk_writeback
    import basilisk::*;
#(
    parameter int OUTPUT_REGISTER_MODE = 1
) (
    input  logic               clk,
    input  logic               rst,
    std_stream_intf.in         mult_result_command,
    std_stream_intf.in         add_result_command,
    std_stream_intf.out        writeback_command,
    input  logic               fflags_clear,
    output logic [FLAGS_W-1:0] fflags
);

    basilisk_result_t    add_pl;
    basilisk_result_t    mult_pl;
    basilisk_writeback_t sel_pl;
    basilisk_writeback_t out_pl;
    logic                out_v;
    logic [1:0]          req;
    logic [1:0]          grant;
    logic                stage_rdy;
    logic                in_fire;
    logic                out_fire;
    logic [FLAGS_W-1:0]  fflags_q;
    logic [FLAGS_W-1:0]  fflags_d;

    assign add_pl  = add_result_command.data;
    assign mult_pl = mult_result_command.data;
    assign req     = {mult_result_command.valid, add_result_command.valid};

    // grant depends only on valids, never on downstream ready
    basilisk_rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .accept (in_fire),
        .grant  (grant)
    );

    assign sel_pl  = grant[1] ? to_writeback(mult_pl) : to_writeback(add_pl);
    assign in_fire = (|grant) && stage_rdy;

    assign add_result_command.ready  = grant[0] && stage_rdy;
    assign mult_result_command.ready = grant[1] && stage_rdy;

    generate
        if (OUTPUT_REGISTER_MODE != 0) begin : g_reg
            logic                out_v_q;
            logic                out_v_d;
            basilisk_writeback_t out_q;
            basilisk_writeback_t out_d;

            assign stage_rdy = !out_v_q || writeback_command.ready;

            always_comb begin
                out_v_d = out_v_q;
                out_d   = out_q;
                if (stage_rdy) begin
                    out_v_d = |grant;
                    out_d   = sel_pl;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_v_q <= 1'b0;
                    out_q   <= '0;
                end else begin
                    out_v_q <= out_v_d;
                    out_q   <= out_d;
                end
            end

            assign out_v  = out_v_q;
            assign out_pl = out_q;
        end else begin : g_comb
            assign stage_rdy = writeback_command.ready;
            assign out_v     = |grant;
            assign out_pl    = sel_pl;
        end
    endgenerate

    assign writeback_command.valid = out_v;
    assign writeback_command.data  = out_pl;
    assign out_fire = out_v && writeback_command.ready;

    // flags of a transfer survive a simultaneous clear
    always_comb begin
        fflags_d = fflags_clear ? '0 : fflags_q;
        if (out_fire) begin
            fflags_d = fflags_d | out_pl.flags;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fflags_q <= '0;
        end else begin
            fflags_q <= fflags_d;
        end
    end

    assign fflags = fflags_q;

endmodule

// File: tb/tb_basilisk_writeback.sv
// Randomized + directed bench for basilisk_writeback, both output modes.
// Scoreboard: in-order merge queue, fairness, handshake and fflags model.
module tb_basilisk_writeback;
    import basilisk::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    std_stream_intf #(.W(RESULT_W)) a1 ();
    std_stream_intf #(.W(RESULT_W)) m1 ();
    std_stream_intf #(.W(RESULT_W)) w1 ();
    std_stream_intf #(.W(RESULT_W)) a0 ();
    std_stream_intf #(.W(RESULT_W)) m0 ();
    std_stream_intf #(.W(RESULT_W)) w0 ();

    logic               a_v = 1'b0;
    logic               m_v = 1'b0;
    basilisk_result_t   a_d = '0;
    basilisk_result_t   m_d = '0;
    logic               wb_rdy = 1'b0;
    logic               clr = 1'b0;
    logic [FLAGS_W-1:0] ff0;
    logic [FLAGS_W-1:0] ff1;
    logic               sel0 = 1'b0;

    assign a1.valid = a_v;
    assign a1.data  = a_d;
    assign m1.valid = m_v;
    assign m1.data  = m_d;
    assign w1.ready = wb_rdy;
    assign a0.valid = a_v;
    assign a0.data  = a_d;
    assign m0.valid = m_v;
    assign m0.data  = m_d;
    assign w0.ready = wb_rdy;

    basilisk_writeback #(.OUTPUT_REGISTER_MODE(1)) u_dut1 (
        .clk                 (clk),
        .rst                 (rst),
        .mult_result_command (m1),
        .add_result_command  (a1),
        .writeback_command   (w1),
        .fflags_clear        (clr),
        .fflags              (ff1)
    );

    basilisk_writeback #(.OUTPUT_REGISTER_MODE(0)) u_dut0 (
        .clk                 (clk),
        .rst                 (rst),
        .mult_result_command (m0),
        .add_result_command  (a0),
        .writeback_command   (w0),
        .fflags_clear        (clr),
        .fflags              (ff0)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                      tag, got, exp, $time);
    endtask

    basilisk_result_t a_src[$];
    basilisk_result_t m_src[$];
    basilisk_result_t exp_q[$];
    logic [4:0]       out_log[$];

    logic               a_fired = 1'b0;
    logic               m_fired = 1'b0;
    logic               last_m = 1'b1;
    logic [FLAGS_W-1:0] mff = '0;
    logic               prev_stall = 1'b0;
    logic               prev_fire = 1'b0;
    basilisk_writeback_t prev_d = '0;

    logic                ardy, mrdy, wbv, ffv;
    basilisk_writeback_t wbd;

    always_comb begin
        ardy = sel0 ? a0.ready : a1.ready;
        mrdy = sel0 ? m0.ready : m1.ready;
        wbv  = sel0 ? w0.valid : w1.valid;
        wbd  = sel0 ? w0.data  : w1.data;
        ffv  = sel0 ? |1'b0 : |1'b0;
    end

    wire [FLAGS_W-1:0] ff = sel0 ? ff0 : ff1;

    always @(negedge clk) begin
        logic stage_ok, exp_acc, any_in, out_f;
        basilisk_result_t in_d, e;
        if (rst) begin
            exp_q.delete();
            last_m     = 1'b1;
            mff        = '0;
            a_fired    = 1'b0;
            m_fired    = 1'b0;
            prev_stall = 1'b0;
            prev_fire  = 1'b0;
        end else begin
            a_fired  = a_v && ardy;
            m_fired  = m_v && mrdy;
            any_in   = a_fired || m_fired;
            stage_ok = sel0 ? wb_rdy : (!wbv || wb_rdy);
            exp_acc  = (a_v || m_v) && stage_ok;
            out_f    = wbv && wb_rdy;
            check("one_ready", 64'(ardy && mrdy), 64'(0));
            check("accept", 64'(any_in), 64'(exp_acc));
            if (a_v && m_v && exp_acc)
                check("rr_winner", 64'(m_fired), 64'(!last_m));
            if (any_in) last_m = m_fired;
            if (!wb_rdy && (sel0 || wbv))
                check("stall_rdy", 64'({ardy, mrdy}), 64'(0));
            if (sel0) check("m0_valid", 64'(wbv), 64'(a_v || m_v));
            if (prev_fire) check("lat1", 64'(wbv), 64'(1));
            if (prev_stall) begin
                check("hold_v", 64'(wbv), 64'(1));
                check("hold_d", 64'(wbd), 64'(prev_d));
            end
            in_d = m_fired ? m_d : a_d;
            if (sel0 && any_in) exp_q.push_back(in_d);
            if (out_f) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("payload", 64'(wbd), 64'(e));
                end
                out_log.push_back(wbd.dest_reg_addr);
            end
            if (!sel0 && any_in) exp_q.push_back(in_d);
            check("fflags", 64'(ff), 64'(mff));
            mff = (clr ? '0 : mff) | (out_f ? wbd.flags : '0);
            prev_stall = !sel0 && wbv && !wb_rdy;
            prev_fire  = !sel0 && any_in;
            prev_d     = wbd;
        end
    end

    task automatic step(input int gap, input int rdy_pct, input int clr_pct);
        @(posedge clk);
        #1;
        if (a_v && a_fired) a_v = 1'b0;
        if (m_v && m_fired) m_v = 1'b0;
        if (!a_v && a_src.size() > 0 && $urandom_range(99) >= gap) begin
            a_d = a_src.pop_front();
            a_v = 1'b1;
        end
        if (!m_v && m_src.size() > 0 && $urandom_range(99) >= gap) begin
            m_d = m_src.pop_front();
            m_v = 1'b1;
        end
        wb_rdy = (int'($urandom_range(99)) < rdy_pct);
        clr    = (int'($urandom_range(99)) < clr_pct);
    endtask

    task automatic drain();
        int n = 0;
        while ((a_src.size() > 0 || m_src.size() > 0 || a_v || m_v ||
                exp_q.size() > 0) && n < 300) begin
            step(0, 100, 0);
            n++;
        end
        check("drain", 64'(a_v || m_v || exp_q.size() > 0), 64'(0));
    endtask

    task automatic do_reset();
        a_src.delete();
        m_src.delete();
        a_v = 1'b0;
        m_v = 1'b0;
        rst = 1'b1;
        step(0, 100, 0);
        step(0, 100, 0);
        rst = 1'b0;
        out_log.delete();
    endtask

    function automatic basilisk_result_t mk(input logic [4:0] rd,
                                            input logic [31:0] v,
                                            input logic [4:0] f);
        basilisk_result_t r;
        r.dest_reg_addr = rd;
        r.result        = v;
        r.flags         = f;
        return r;
    endfunction

    task automatic run_mode();
        logic [4:0] exp_ord [8];
        logic [4:0] nvf;
        do_reset();
        check("rst_valid", 64'(wbv), 64'(0));
        check("rst_fflags", 64'(ff), 64'(0));

        // single source
        m_src.push_back(mk(5'd3, 32'h3F80_0000, 5'b00001));
        drain();
        check("single_cnt", 64'(out_log.size()), 64'(1));
        if (out_log.size() > 0) check("single_rd", 64'(out_log[0]), 64'(3));
        check("single_ff", 64'(ff), 64'(5'b00001));

        // contention straight after reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a_src.push_back(mk(5'(1 + i), $urandom, 5'b0));
            m_src.push_back(mk(5'(9 + i), $urandom, 5'b0));
            exp_ord[2*i]   = 5'(1 + i);
            exp_ord[2*i+1] = 5'(9 + i);
        end
        drain();
        check("cont_cnt", 64'(out_log.size()), 64'(8));
        for (int i = 0; i < 8 && i < out_log.size(); i++)
            check("cont_order", 64'(out_log[i]), 64'(exp_ord[i]));

        // backpressure with a held rd=7
        out_log.delete();
        a_src.push_back(mk(5'd7, $urandom, 5'b0));
        m_src.push_back(mk(5'd21, $urandom, 5'b0));
        for (int i = 0; i < 6; i++) step(0, 0, 0);
        drain();
        check("bp_cnt", 64'(out_log.size()), 64'(2));
        if (out_log.size() == 2) begin
            check("bp_first", 64'(out_log[0]), 64'(7));
            check("bp_second", 64'(out_log[1]), 64'(21));
        end

        // clear colliding with a transfer
        nvf = '0;
        nvf[FFLAG_NV] = 1'b1;
        a_src.push_back(mk(5'd5, $urandom, nvf));
        drain();
        check("ff_nv", 64'(ff), 64'(5'b10000));
        a_src.push_back(mk(5'd5, $urandom, 5'b00010));
        step(0, 0, 0);
        step(0, 0, 0);
        check("coll_pending", 64'(wbv), 64'(1));
        step(0, 100, 100);
        step(0, 100, 0);
        check("ff_collide", 64'(ff), 64'(5'b00010));

        // reset while stalled
        a_src.push_back(mk(5'd6, $urandom, 5'b00100));
        step(0, 0, 0);
        step(0, 0, 0);
        rst = 1'b1;
        step(0, 0, 0);
        rst = 1'b0;
        out_log.delete();
        check("rst_stall_v", 64'(wbv), 64'(sel0 ? a_v : 1'b0));
        check("rst_stall_ff", 64'(ff), 64'(0));
        a_src.push_back(mk(5'd8, $urandom, 5'b0));
        m_src.push_back(mk(5'd22, $urandom, 5'b0));
        drain();
        if (out_log.size() > 0)
            check("rst_add_first", 64'(out_log[0] < 5'd16), 64'(1));
        else
            check("rst_out_cnt", 64'(out_log.size()), 64'(2));

        // random traffic
        for (int i = 0; i < 60; i++) begin
            a_src.push_back(mk(5'($urandom_range(15)), $urandom,
                               5'($urandom_range(31))));
            m_src.push_back(mk(5'($urandom_range(31, 16)), $urandom,
                               5'($urandom_range(31))));
        end
        for (int i = 0; i < 250; i++) step(30, 70, 5);
        drain();
    endtask

    initial begin
        sel0 = 1'b0;
        run_mode();
        sel0 = 1'b1;
        run_mode();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
